// File: rtl/ram_arb_2432.sv
// ram_arb_2432: shares one synchronous data RAM between the cpu_2432 data
// port and a host (loader/debugger) port. The host wins idle cycles for free
// and steals a cycle from the CPU after STARVE_MAX waits; HOLD parks the CPU
// so the host can stream accesses every cycle.
//
// Handshake: the host holds i_host_valid and its address/data/byte enables
// stable until it sees o_host_ready high in the same cycle; that cycle is
// the transfer. A granted read returns o_host_rvalid/o_host_rdata one
// enabled cycle later. The CPU side has no handshake: it is frozen through
// o_cpu_clk_en and simply re-presents the same access on the next cycle.
`timescale 1ns/1ps
module ram_arb_2432 #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rstb,
  input  logic        i_clk_en,
  input  logic [23:0] i_cpu_daddr,
  input  logic [31:0] i_cpu_dout,
  input  logic        i_cpu_ram_rd,
  input  logic [3:0]  i_cpu_ram_wr,
  output logic [31:0] o_cpu_din,
  output logic        o_cpu_clk_en,
  input  logic        i_host_valid,
  output logic        o_host_ready,
  input  logic [23:0] i_host_addr,
  input  logic [31:0] i_host_wdata,
  input  logic [3:0]  i_host_wr,
  input  logic        i_host_hold,
  output logic        o_hold_ack,
  output logic        o_host_rvalid,
  output logic [31:0] o_host_rdata,
  output logic [23:0] o_ram_addr,
  output logic [31:0] o_ram_wdata,
  output logic        o_ram_rd,
  output logic [3:0]  o_ram_wr,
  input  logic [31:0] i_ram_rdata,
  output logic        o_dbg_state
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state_q;
  logic        hold_ack_q;
  logic [3:0]  starve_cnt;
  logic        cpu_rd_q;
  logic [31:0] hold_q;
  logic        host_rvalid_q;

  logic        cpu_acc;
  logic        host_grant;
  logic        cpu_rd_issue;
  logic        in_run;

  assign in_run = (state_q == ST_RUN);

  // Ownership decision: host takes idle cycles, or steals once starved.
  always_comb begin
    cpu_acc    = i_cpu_ram_rd | (|i_cpu_ram_wr);
    host_grant = 1'b0;
    if (state_q == ST_HOLD) begin
      host_grant = i_host_valid;
    end else begin
      host_grant = i_host_valid & (!cpu_acc | (starve_cnt == STARVE_LIM));
    end
  end

  // A CPU read reaches the RAM only when the CPU owns this enabled cycle.
  assign cpu_rd_issue = in_run & !host_grant & i_cpu_ram_rd;

  assign o_cpu_clk_en = i_clk_en & in_run & !(host_grant & cpu_acc);
  assign o_host_ready = i_clk_en & host_grant;

  // RAM port mux: host on grant, else CPU pass-through in RUN, else quiet.
  always_comb begin
    o_ram_addr  = i_cpu_daddr;
    o_ram_wdata = i_cpu_dout;
    o_ram_rd    = 1'b0;
    o_ram_wr    = 4'h0;
    if (host_grant) begin
      o_ram_addr  = i_host_addr;
      o_ram_wdata = i_host_wdata;
    end
    if (i_clk_en) begin
      if (host_grant) begin
        o_ram_rd = (i_host_wr == 4'h0);
        o_ram_wr = i_host_wr;
      end else if (in_run) begin
        o_ram_rd = i_cpu_ram_rd;
        o_ram_wr = i_cpu_ram_wr;
      end
    end
  end

  // RUN/HOLD FSM with registered hold acknowledge.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      state_q    <= ST_RUN;
      hold_ack_q <= 1'b0;
    end else if (i_clk_en) begin
      if (i_host_hold) begin
        state_q    <= ST_HOLD;
        hold_ack_q <= 1'b1;
      end else begin
        state_q    <= ST_RUN;
        hold_ack_q <= 1'b0;
      end
    end
  end

  // Host starvation counter: counts refused cycles, saturating at the limit.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      starve_cnt <= 4'h0;
    end else if (i_clk_en) begin
      if (host_grant || !i_host_valid) begin
        starve_cnt <= 4'h0;
      end else if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  // CPU read return: live RAM data right after issue, latched copy after.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      cpu_rd_q <= 1'b0;
      hold_q   <= 32'h0;
    end else if (i_clk_en) begin
      cpu_rd_q <= cpu_rd_issue;
      if (cpu_rd_q) begin
        hold_q <= i_ram_rdata;
      end
    end
  end

  // Host read return pulse, one enabled cycle after a granted read.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      host_rvalid_q <= 1'b0;
    end else if (i_clk_en) begin
      host_rvalid_q <= host_grant & (i_host_wr == 4'h0);
    end
  end

  assign o_cpu_din     = cpu_rd_q ? i_ram_rdata : hold_q;
  assign o_host_rvalid = host_rvalid_q;
  assign o_host_rdata  = host_rvalid_q ? i_ram_rdata : 32'h0;
  assign o_hold_ack    = hold_ack_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_ram_arb_2432.sv
// Bench for ram_arb_2432: behavioural RAM, reference memory for expected
// read data, table of single-cycle arbitration vectors and hand-written
// multi-cycle sequences. Host read results go through an expected queue.
`timescale 1ns/1ps
module tb_ram_arb_2432;

  localparam int SM = 4;

  // ---------------- clock / reset ----------------
  logic        i_clk = 1'b0;
  logic        i_rstb = 1'b0;
  logic        i_clk_en = 1'b1;
  logic [23:0] i_cpu_daddr = '0;
  logic [31:0] i_cpu_dout = '0;
  logic        i_cpu_ram_rd = 1'b0;
  logic [3:0]  i_cpu_ram_wr = '0;
  logic        i_host_valid = 1'b0;
  logic [23:0] i_host_addr = '0;
  logic [31:0] i_host_wdata = '0;
  logic [3:0]  i_host_wr = '0;
  logic        i_host_hold = 1'b0;
  logic [31:0] i_ram_rdata;
  logic [31:0] o_cpu_din;
  logic        o_cpu_clk_en;
  logic        o_host_ready;
  logic        o_hold_ack;
  logic        o_host_rvalid;
  logic [31:0] o_host_rdata;
  logic [23:0] o_ram_addr;
  logic [31:0] o_ram_wdata;
  logic        o_ram_rd;
  logic [3:0]  o_ram_wr;
  logic        o_dbg_state;

  always #5 i_clk = ~i_clk;

  ram_arb_2432 #(.STARVE_MAX(SM)) dut (
    .i_clk(i_clk), .i_rstb(i_rstb), .i_clk_en(i_clk_en),
    .i_cpu_daddr(i_cpu_daddr), .i_cpu_dout(i_cpu_dout),
    .i_cpu_ram_rd(i_cpu_ram_rd), .i_cpu_ram_wr(i_cpu_ram_wr),
    .o_cpu_din(o_cpu_din), .o_cpu_clk_en(o_cpu_clk_en),
    .i_host_valid(i_host_valid), .o_host_ready(o_host_ready),
    .i_host_addr(i_host_addr), .i_host_wdata(i_host_wdata),
    .i_host_wr(i_host_wr), .i_host_hold(i_host_hold),
    .o_hold_ack(o_hold_ack), .o_host_rvalid(o_host_rvalid),
    .o_host_rdata(o_host_rdata), .o_ram_addr(o_ram_addr),
    .o_ram_wdata(o_ram_wdata), .o_ram_rd(o_ram_rd), .o_ram_wr(o_ram_wr),
    .i_ram_rdata(i_ram_rdata), .o_dbg_state(o_dbg_state)
  );

  // ---------------- behavioural RAM ----------------
  logic [31:0] mem [logic [23:0]];
  logic [31:0] ram_q = 32'h0;
  assign i_ram_rdata = ram_q;

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  always @(posedge i_clk) begin
    logic [31:0] cur;
    cur = mem.exists(o_ram_addr) ? mem[o_ram_addr] : 32'h0;
    if (o_ram_rd) ram_q <= cur;
    if (o_ram_wr != 4'h0) mem[o_ram_addr] = merge(cur, o_ram_wdata, o_ram_wr);
  end

  // ---------------- reference memory ----------------
  logic [31:0] ref_mem [logic [23:0]];

  function automatic logic [31:0] ref_rd(input logic [23:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic ref_wr(input logic [23:0] a, input logic [31:0] d, input logic [3:0] be);
    ref_mem[a] = merge(ref_rd(a), d, be);
  endtask

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rstb && i_clk_en && o_host_rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL host_rvalid_unexpected actual=1 required=0");
      end else begin
        chk("host_rdata", o_host_rdata, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_clk_en     = 1'b1;
    i_cpu_ram_rd = 1'b0;
    i_cpu_ram_wr = 4'h0;
    i_host_valid = 1'b0;
    i_host_wr    = 4'h0;
    i_host_hold  = 1'b0;
  endtask

  task automatic host_idle_read(input logic [23:0] a);
    i_host_valid = 1'b1;
    i_host_addr  = a;
    i_host_wr    = 4'h0;
    @(negedge i_clk);
    chk("idle_rd_ready", o_host_ready, 1);
    chk("idle_rd_cpu_ce", o_cpu_clk_en, 1);
    if (o_host_ready) exp_q.push_back(ref_rd(a));
    tick();
    i_host_valid = 1'b0;
    @(negedge i_clk);
    chk("idle_rd_rvalid", o_host_rvalid, 1);
    tick();
  endtask

  task automatic host_idle_write(input logic [23:0] a, input logic [31:0] d);
    i_host_valid = 1'b1;
    i_host_addr  = a;
    i_host_wdata = d;
    i_host_wr    = 4'hF;
    @(negedge i_clk);
    chk("idle_wr_ready", o_host_ready, 1);
    ref_wr(a, d, 4'hF);
    tick();
    i_host_valid = 1'b0;
    i_host_wr    = 4'h0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       ce;
    logic       crd;
    logic [3:0] cwr;
    logic       hv;
    logic [3:0] hwr;
    logic       x_rdy;
    logic       x_cce;
    logic       x_rrd;
    logic [3:0] x_rwr;
    logic       x_hsel;
  } vec_t;

  vec_t vt [11];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gcyc;
    logic [23:0] wa;
    logic [31:0] wd;

    //           ce   crd  cwr   hv   hwr   rdy  cce  rrd  rwr   hsel
    vt[0]  = '{1'b1,1'b0,4'h0,1'b0,4'h0, 1'b0,1'b1,1'b0,4'h0,1'b0};
    vt[1]  = '{1'b1,1'b1,4'h0,1'b0,4'h0, 1'b0,1'b1,1'b1,4'h0,1'b0};
    vt[2]  = '{1'b1,1'b0,4'hF,1'b0,4'h0, 1'b0,1'b1,1'b0,4'hF,1'b0};
    vt[3]  = '{1'b1,1'b0,4'h0,1'b1,4'h0, 1'b1,1'b1,1'b1,4'h0,1'b1};
    vt[4]  = '{1'b1,1'b0,4'h0,1'b1,4'hF, 1'b1,1'b1,1'b0,4'hF,1'b1};
    vt[5]  = '{1'b1,1'b1,4'h0,1'b1,4'h0, 1'b0,1'b1,1'b1,4'h0,1'b0};
    vt[6]  = '{1'b1,1'b0,4'hF,1'b1,4'hF, 1'b0,1'b1,1'b0,4'hF,1'b0};
    vt[7]  = '{1'b0,1'b1,4'h0,1'b1,4'h0, 1'b0,1'b0,1'b0,4'h0,1'b0};
    vt[8]  = '{1'b1,1'b0,4'h3,1'b0,4'h0, 1'b0,1'b1,1'b0,4'h3,1'b0};
    vt[9]  = '{1'b1,1'b0,4'h0,1'b1,4'h1, 1'b1,1'b1,1'b0,4'h1,1'b1};
    vt[10] = '{1'b1,1'b0,4'h0,1'b1,4'h0, 1'b1,1'b1,1'b1,4'h0,1'b1};

    // Reset values
    idle();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_rvalid", o_host_rvalid, 0);
    chk("rst_rdata", o_host_rdata, 0);
    chk("rst_cpu_din", o_cpu_din, 0);
    chk("rst_hold_ack", o_hold_ack, 0);
    chk("rst_cpu_ce", o_cpu_clk_en, 1);
    #1 i_rstb = 1'b1;
    tick();

    // Table-driven single-cycle arbitration vectors
    for (int i = 0; i < 11; i++) begin
      i_clk_en     = vt[i].ce;
      i_cpu_ram_rd = vt[i].crd;
      i_cpu_ram_wr = vt[i].cwr;
      i_cpu_daddr  = 24'h000100;
      i_cpu_dout   = 32'h1111_0000 | 32'(i * 32'h0101);
      i_host_valid = vt[i].hv;
      i_host_wr    = vt[i].hwr;
      i_host_addr  = 24'h000200;
      i_host_wdata = 32'h2222_0000 | 32'(i * 32'h0303);
      @(negedge i_clk);
      chk("vec_ready", o_host_ready, vt[i].x_rdy);
      chk("vec_cpu_ce", o_cpu_clk_en, vt[i].x_cce);
      chk("vec_ram_rd", o_ram_rd, vt[i].x_rrd);
      chk("vec_ram_wr", o_ram_wr, vt[i].x_rwr);
      if (vt[i].x_rrd || vt[i].x_rwr != 4'h0)
        chk("vec_ram_addr", o_ram_addr, vt[i].x_hsel ? 24'h000200 : 24'h000100);
      if (vt[i].x_rwr != 4'h0)
        chk("vec_ram_wdata", o_ram_wdata, vt[i].x_hsel ? i_host_wdata : i_cpu_dout);
      if (vt[i].x_rdy && vt[i].hwr == 4'h0) exp_q.push_back(ref_rd(24'h000200));
      if (vt[i].x_rwr != 4'h0)
        ref_wr(vt[i].x_hsel ? 24'h000200 : 24'h000100,
               vt[i].x_hsel ? i_host_wdata : i_cpu_dout, vt[i].x_rwr);
      tick();
      idle();
      tick();
    end

    // CPU-only write then read of 0x10
    i_cpu_daddr  = 24'h000010;
    i_cpu_dout   = 32'hDEADBEEF;
    i_cpu_ram_wr = 4'hF;
    @(negedge i_clk);
    chk("cpu_wr_ce", o_cpu_clk_en, 1);
    chk("cpu_wr_strobe", o_ram_wr, 4'hF);
    ref_wr(24'h000010, 32'hDEADBEEF, 4'hF);
    tick();
    i_cpu_ram_wr = 4'h0;
    i_cpu_ram_rd = 1'b1;
    @(negedge i_clk);
    chk("cpu_rd_ce", o_cpu_clk_en, 1);
    tick();
    i_cpu_ram_rd = 1'b0;
    @(negedge i_clk);
    chk("cpu_rd_data", o_cpu_din, ref_rd(24'h000010));
    chk("cpu_rd_ce2", o_cpu_clk_en, 1);
    tick();

    // Host read in an idle gap
    host_idle_read(24'h000010);

    // Starvation: CPU reads every cycle, host waits STARVE_MAX cycles
    i_cpu_daddr  = 24'h000014;
    i_cpu_ram_rd = 1'b1;
    i_host_valid = 1'b1;
    i_host_addr  = 24'h000010;
    i_host_wr    = 4'h0;
    gcyc = 0;
    for (int c = 1; c <= 10 && gcyc == 0; c++) begin
      @(negedge i_clk);
      if (o_host_ready) begin
        gcyc = c;
        chk("starve_steal_ce", o_cpu_clk_en, 0);
        exp_q.push_back(ref_rd(24'h000010));
      end else begin
        chk("starve_wait_ce", o_cpu_clk_en, 1);
      end
      tick();
    end
    chk("starve_grant_cycle", gcyc, SM + 1);
    i_host_valid = 1'b0;
    @(negedge i_clk);
    chk("starve_resume_ce", o_cpu_clk_en, 1);
    chk("starve_resume_rd", o_ram_rd, 1);
    chk("starve_resume_addr", o_ram_addr, 24'h000014);
    tick();
    idle();
    tick();

    // Load then steal
    host_idle_write(24'h000020, 32'h12345678);
    host_idle_write(24'h000030, 32'hCAFEF00D);
    i_cpu_daddr  = 24'h000020;
    i_cpu_ram_rd = 1'b1;
    i_host_valid = 1'b1;
    i_host_addr  = 24'h000030;
    for (int c = 1; c <= SM; c++) begin
      @(negedge i_clk);
      chk("ls_wait_ready", o_host_ready, 0);
      tick();
    end
    i_cpu_daddr = 24'h000040;
    @(negedge i_clk);
    chk("ls_steal_ready", o_host_ready, 1);
    chk("ls_steal_ce", o_cpu_clk_en, 0);
    if (o_host_ready) exp_q.push_back(ref_rd(24'h000030));
    tick();
    i_host_valid = 1'b0;
    @(negedge i_clk);
    chk("ls_unstall_ce", o_cpu_clk_en, 1);
    chk("ls_cpu_din_held", o_cpu_din, 32'h12345678);
    chk("ls_reissue_addr", o_ram_addr, 24'h000040);
    tick();
    i_cpu_ram_rd = 1'b0;
    @(negedge i_clk);
    chk("ls_cpu_din_next", o_cpu_din, ref_rd(24'h000040));
    tick();

    // HOLD: bulk host writes, CPU parked
    idle();
    i_host_hold = 1'b1;
    @(negedge i_clk);
    chk("hold_ack_early", o_hold_ack, 0);
    chk("hold_ce_early", o_cpu_clk_en, 1);
    tick();
    @(negedge i_clk);
    chk("hold_ack", o_hold_ack, 1);
    chk("hold_ce", o_cpu_clk_en, 0);
    tick();
    i_cpu_ram_rd = 1'b1;
    i_cpu_daddr  = 24'h000010;
    for (int k = 0; k < 16; k++) begin
      wa = 24'h000080 + 24'(k * 4);
      wd = $urandom;
      i_host_valid = 1'b1;
      i_host_addr  = wa;
      i_host_wdata = wd;
      i_host_wr    = 4'hF;
      @(negedge i_clk);
      chk("hold_wr_ready", o_host_ready, 1);
      chk("hold_wr_strobe", o_ram_wr, 4'hF);
      chk("hold_wr_addr", o_ram_addr, wa);
      ref_wr(wa, wd, 4'hF);
      tick();
    end
    idle();
    @(negedge i_clk);
    chk("hold_exit_ce", o_cpu_clk_en, 0);
    chk("hold_exit_ack", o_hold_ack, 1);
    tick();
    @(negedge i_clk);
    chk("run_ce", o_cpu_clk_en, 1);
    chk("run_ack", o_hold_ack, 0);
    tick();
    host_idle_read(24'h000080);
    host_idle_read(24'h0000BC);

    // Reset mid host read
    i_host_valid = 1'b1;
    i_host_addr  = 24'h000020;
    i_host_wr    = 4'h0;
    @(negedge i_clk);
    chk("rstmid_ready", o_host_ready, 1);
    #2 i_rstb = 1'b0;
    #1;
    chk("rstmid_rvalid", o_host_rvalid, 0);
    chk("rstmid_cpu_din", o_cpu_din, 0);
    chk("rstmid_rdata", o_host_rdata, 0);
    chk("rstmid_hold_ack", o_hold_ack, 0);
    idle();
    tick();
    @(negedge i_clk);
    chk("rstmid_rvalid2", o_host_rvalid, 0);
    chk("rstmid_ce", o_cpu_clk_en, 1);
    #1 i_rstb = 1'b1;
    tick();

    // Clock enable low freezes the starvation counter
    i_cpu_daddr  = 24'h000010;
    i_cpu_ram_rd = 1'b1;
    i_host_valid = 1'b1;
    i_host_addr  = 24'h000030;
    for (int c = 0; c < 2; c++) begin
      @(negedge i_clk);
      chk("ce_pre_ready", o_host_ready, 0);
      tick();
    end
    i_clk_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      chk("ce_off_ready", o_host_ready, 0);
      chk("ce_off_cpu_ce", o_cpu_clk_en, 0);
      chk("ce_off_rd", o_ram_rd, 0);
      chk("ce_off_wr", o_ram_wr, 0);
      tick();
    end
    i_clk_en = 1'b1;
    gcyc = 0;
    for (int c = 1; c <= 8 && gcyc == 0; c++) begin
      @(negedge i_clk);
      if (o_host_ready) begin
        gcyc = c;
        exp_q.push_back(ref_rd(24'h000030));
      end
      tick();
    end
    chk("ce_frozen_grant_cycle", gcyc, SM - 1);
    idle();
    repeat (3) tick();

    chk("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arb_2432.md
# ram_arb_2432

Single-port data-RAM arbiter for the cpu_2432 core. It shares one synchronous data RAM between the CPU data port and a host port (loader/debugger) using a valid/ready handshake. It stalls the CPU through its clock-enable whenever the host takes a cycle, and can hold the CPU stopped for bulk program load. It sits between the cpu_2432 data-port outputs, `i_din`, `i_clk_en`, and the RAM macro.

## Interface
Parameters:
- STARVE_MAX, 4: host wait cycles tolerated before a forced steal; legal range 1..15.

Ports:
- i_clk  in  1  clock
- i_rstb  in  1  reset, asynchronous, active-low
- i_clk_en  in  1  global clock enable; all state advances only when high
- i_cpu_daddr  in  24  CPU data address
- i_cpu_dout  in  32  CPU write data, already byte-lane aligned
- i_cpu_ram_rd  in  1  CPU read request
- i_cpu_ram_wr  in  4  CPU byte write enables
- o_cpu_din  out  32  read data to the CPU `i_din`
- o_cpu_clk_en  out  1  clock enable to the CPU
- i_host_valid  in  1  host request
- o_host_ready  out  1  host request accepted this cycle
- i_host_addr  in  24  host address
- i_host_wdata  in  32  host write data
- i_host_wr  in  4  host byte enables; 0 means read
- i_host_hold  in  1  request CPU halt
- o_hold_ack  out  1  CPU halted, FSM in HOLD
- o_host_rvalid  out  1  host read data valid
- o_host_rdata  out  32  host read data
- o_ram_addr  out  24  RAM address
- o_ram_wdata  out  32  RAM write data
- o_ram_rd  out  1  RAM read strobe
- o_ram_wr  out  4  RAM byte write strobes
- i_ram_rdata  in  32  RAM read data, valid the enabled cycle after `o_ram_rd`

## Operation
- cpu_acc = `i_cpu_ram_rd | (|i_cpu_ram_wr)`.
- FSM states RUN and HOLD; reset state is RUN.
- RUN to HOLD when `i_host_hold` is high. HOLD to RUN when `i_host_hold` is low. Both transitions occur only on enabled edges.
- RUN grant rule:
  - host_grant = `i_host_valid & (!cpu_acc | starve_cnt == STARVE_MAX)`.
  - Otherwise, the CPU owns the RAM.
- HOLD grant rule: host_grant = `i_host_valid`. The CPU never accesses RAM in HOLD.
- `o_cpu_clk_en` = `i_clk_en & state==RUN & !(host_grant & cpu_acc)`.
  - On a steal the CPU is frozen and re-presents the same access next cycle. It is never lost or duplicated.
- `o_host_ready` = `i_clk_en & host_grant`.
- RAM mux when `i_clk_en` is high:
  - On host_grant: host addr/wdata drive the RAM. `o_ram_rd` = (`i_host_wr`==0). `o_ram_wr` = `i_host_wr`.
  - Else in RUN: CPU signals pass through.
  - Else: `o_ram_rd`=0 and `o_ram_wr`=0.
- When `i_clk_en` is low, all strobes are 0. Address and data are don't-care.
- starve_cnt (4b):
  - Clears on host_grant or on `!i_host_valid`.
  - Increments when `i_host_valid` is high and no grant is given.
  - Saturates at STARVE_MAX.
- CPU read return:
  - cpu_rd_q is set on an enabled cycle where the CPU issued a read to RAM; otherwise it clears.
  - `o_cpu_din` = cpu_rd_q ? `i_ram_rdata` : hold_q.
  - hold_q captures `i_ram_rdata` on any enabled cycle with cpu_rd_q high. CPU load data therefore survives a steal or HOLD entered between issue and consume.
- Host read return:
  - `o_host_rvalid` is a registered one-cycle pulse on the enabled cycle after a granted host read.
  - `o_host_rdata` = `o_host_rvalid` ? `i_ram_rdata` : 0.
- Host writes produce no rvalid.

## Timing
- Reset values:
  - state RUN, starve_cnt 0, cpu_rd_q 0, hold_q 0, `o_host_rvalid` 0, `o_hold_ack` 0.
  - `o_host_rdata` 0; `o_cpu_din` 0.
  - `o_cpu_clk_en` equals `i_clk_en`.
- Host read latency: grant at cycle N, rdata/rvalid at N+1 (enabled cycles).
- A host stall costs the CPU exactly one cycle per steal.
- Worst-case host wait in RUN is STARVE_MAX+1 enabled cycles.
- HOLD entry: `o_hold_ack` and CPU stop begin on the cycle after `i_host_hold` is sampled high. Exit has a one-cycle latency.
- Simultaneous CPU read consumption and host grant is legal. The CPU reads via hold_q on its next enabled cycle.
- Reset mid-operation: all state clears immediately. An in-flight host read returns no rvalid.
- While `i_clk_en` is low, nothing changes, including counter, pulses and hold_q.

## Test plan
- CPU-only: CPU writes 0xDEADBEEF to 0x000010, then reads it back. `o_cpu_clk_en` stays 1 and `o_cpu_din`=0xDEADBEEF the cycle after the read.
- Host in an idle gap: `i_host_valid` read 0x000010 while cpu_acc=0. Ready is the same cycle, rvalid the next cycle with rdata 0xDEADBEEF, and no CPU stall.
- Starvation: CPU accesses every cycle with host valid and STARVE_MAX=4. The grant occurs on the 5th cycle, `o_cpu_clk_en`=0 for exactly that cycle, and the CPU access completes on the following cycle.
- Load then steal: CPU read of 0x20 (data 0x12345678) followed immediately by a forced steal of a host read of 0x30 (0xCAFEF00D). The CPU gets 0x12345678 after the unstall; the host gets 0xCAFEF00D.
- HOLD: assert `i_host_hold`. `o_hold_ack`=1 and `o_cpu_clk_en`=0 from the next cycle. 16 back-to-back host writes are all ready in consecutive cycles. Deassert and the CPU resumes one cycle later.
- Reset and enable: reset asserted mid host read gives no rvalid and all outputs at reset values. With `i_clk_en`=0 for 3 cycles, there are no strobes and the counter is frozen.
